fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and hazard controller for the pipelined RV32I core; the successor to the fixed 2-bit rs1mux/rs2mux forwarding selects.
- Tracks in-flight destination registers in a shadow shift register (stage 0 = EX, 1 = MEM, 2 = WB, ...).
- Produces registered per-operand forwarding selects for the instruction in EX, a load-use stall for ID, and bubble insertion.
- Honours dcache freeze and branch flush.

Parameters:
- NSRC, 2: number of source operands checked per instruction (rs1, rs2, ...).
- DEPTH, 3: tracked stages after ID (EX..WB); minimum 2.
- REGW, 5: register index width.
- LOAD_STAGE, 2: first stage index whose load data is forwardable (2 = MEM/WB register).
- SELW, $clog2(DEPTH): width of one forwarding select.
- CNTW, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  NSRC*REGW  source indices; operand i at [i*REGW +: REGW]
- id_rs_used  in  NSRC  operand i is actually read
- id_rd  in  REGW  destination of the ID instruction
- id_wr_en  in  1  ID instruction writes id_rd
- id_is_load  in  1  ID instruction is a load
- freeze  in  1  dcache/icache wait; whole pipe holds
- flush  in  1  branch/jump taken in EX; kill ID
- fwd_sel  out  NSRC*SELW  registered; select for EX operand i: 0 = regfile/ID/EX value, j = result held in stage j (1 = EX/MEM, 2 = MEM/WB, ...)
- stall_id  out  1  combinational; hold PC, IF/ID
- bubble_ex  out  1  registered; EX holds a bubble
- stall_cnt  out  CNTW  load-use stall cycles, saturating

Behaviour:
- Shadow entry per stage: {v, rd, ld}; entry valid for matching only if v && rd != 0.
- Reset:
  - All entries v = 0.
  - fwd_sel = 0, bubble_ex = 1, stall_cnt = 0.
  - stall_id = 0 while rst is high.
- Match (combinational, per operand i with id_rs_used[i] && id_valid):
  - k = smallest stage index with a valid entry whose rd == rs_i (youngest producer wins).
  - No match, or k == DEPTH-1 (retiring; regfile write-through) → next select 0.
  - Otherwise next select = k+1.
- Load-use:
  - stall_id = 1 if any used operand matches (youngest) entry k with ld = 1 and k+1 < LOAD_STAGE.
  - Forced to 0 when flush = 1 or rst = 1.
  - stall_id is asserted during freeze but has no effect.
- Update priority each clock: rst > freeze > flush > stall > normal.
  - freeze: all state, fwd_sel, bubble_ex and stall_cnt hold.
  - flush: entries shift (entry j ← entry j-1); stage 0 ← bubble (v = 0); fwd_sel ← 0; bubble_ex ← 1.
  - stall: shift; stage 0 ← bubble; fwd_sel ← 0; bubble_ex ← 1; stall_cnt += 1, saturating at all-ones.
  - normal: shift; stage 0 ← {id_valid && id_wr_en, id_rd, id_is_load}; fwd_sel ← next selects; bubble_ex ← !id_valid.
- Entry DEPTH-1 falls off each advancing cycle.
- Latency: select decided in ID, valid in the EX cycle (one register).
- Multi-cycle stalls: stall re-evaluates every cycle. With DEPTH = 3 and LOAD_STAGE = 2, a load-use always resolves after exactly 1 stall cycle, then fwd_sel = 2.
- rd = 0 never matches; x0 writes never forward.
- Unused operands (id_rs_used = 0) never stall and get select 0.

Test Plan:
- Reset check: rst 1 cycle → fwd_sel = 0, bubble_ex = 1, stall_cnt = 0; the next instruction reading x5 gets select 0.
- EX forward: add x5 then sub x6,x5,x7 back-to-back → in the sub's EX cycle fwd_sel[op0] = 1, fwd_sel[op1] = 0, stall_id never 1.
- Youngest wins: x5 written by two consecutive instructions, then read → select 1, not 2. Same read one instruction later → select 2. Two later → select 0.
- Load-use: lw x5 then add x6,x5,x5 → stall_id = 1 for exactly 1 cycle, bubble_ex = 1, stall_cnt = 1; then fwd_sel = {2,2}.
- Freeze mid-stall: raise freeze during the load-use stall for 4 cycles → all outputs held, stall_cnt unchanged; after release the stall completes and stall_cnt = 1.
- Flush vs stall: flush = 1 in the same cycle as a load-use hazard → stall_id = 0, stage 0 bubble, next fwd_sel = 0. Also, a write to x0 followed by a read of x0 → select 0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard controller. A shadow shift register tracks the
// destinations of in-flight instructions (stage 0 = EX) and drives registered EX selects.
module fwd_hazard_unit #(
    parameter int unsigned NSRC       = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned REGW       = 5,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned SELW       = $clog2(DEPTH),
    parameter int unsigned CNTW       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*REGW-1:0] id_rs,
    input  logic [NSRC-1:0]      id_rs_used,
    input  logic [REGW-1:0]      id_rd,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    input  logic                 freeze,
    input  logic                 flush,
    output logic [NSRC*SELW-1:0] fwd_sel,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic [CNTW-1:0]      stall_cnt
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] ld_q;
    logic [REGW-1:0]  rd_q [DEPTH];

    logic [NSRC*SELW-1:0] sel_d;
    logic [NSRC-1:0]      load_use;

    always_comb begin
        logic        hit;
        logic        hit_ld;
        int unsigned k;
        sel_d    = '0;
        load_use = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit    = 1'b0;
            hit_ld = 1'b0;
            k      = 0;
            // Scan oldest to youngest so the youngest producer is the one that sticks.
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (v_q[j] && (rd_q[j] != '0) && (rd_q[j] == id_rs[i*REGW +: REGW])) begin
                    hit    = 1'b1;
                    hit_ld = ld_q[j];
                    k      = unsigned'(j);
                end
            end
            if (id_valid && id_rs_used[i] && hit) begin
                // The retiring stage writes through the regfile, so it needs no bypass.
                if (k != DEPTH - 1) begin
                    sel_d[i*SELW +: SELW] = SELW'(k + 1);
                end
                load_use[i] = hit_ld && ((k + 1) < LOAD_STAGE);
            end
        end
    end

    assign stall_id = (|load_use) && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            ld_q      <= '0;
            fwd_sel   <= '0;
            bubble_ex <= 1'b1;
            stall_cnt <= '0;
        end else if (!freeze) begin
            for (int j = DEPTH - 1; j > 0; j--) begin
                v_q[j]  <= v_q[j-1];
                rd_q[j] <= rd_q[j-1];
                ld_q[j] <= ld_q[j-1];
            end
            if (flush || stall_id) begin
                v_q[0]    <= 1'b0;
                rd_q[0]   <= '0;
                ld_q[0]   <= 1'b0;
                fwd_sel   <= '0;
                bubble_ex <= 1'b1;
                if (stall_id && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + CNTW'(1);
                end
            end else begin
                v_q[0]    <= id_valid && id_wr_en;
                rd_q[0]   <= id_rd;
                ld_q[0]   <= id_is_load;
                fwd_sel   <= sel_d;
                bubble_ex <= !id_valid;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed table-driven bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic        id_wr_en;
    logic        id_is_load;
    logic        freeze;
    logic        flush;
    logic [3:0]  fwd_sel;
    logic        stall_id;
    logic        bubble_ex;
    logic [15:0] stall_cnt;

    int tests;
    int fails;

    typedef struct packed {
        logic        rst;
        logic        freeze;
        logic        flush;
        logic        valid;
        logic [4:0]  rs0;
        logic [4:0]  rs1;
        logic [1:0]  used;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        e_stall;
        logic [1:0]  e_sel0;
        logic [1:0]  e_sel1;
        logic        e_bub;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    fwd_hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_wr_en   (id_wr_en),
        .id_is_load (id_is_load),
        .freeze     (freeze),
        .flush      (flush),
        .fwd_sel    (fwd_sel),
        .stall_id   (stall_id),
        .bubble_ex  (bubble_ex),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic fz, input logic fl, input logic va,
                                input logic [4:0] s0, input logic [4:0] s1,
                                input logic [1:0] us, input logic [4:0] d, input logic w,
                                input logic l, input logic es, input logic [1:0] e0,
                                input logic [1:0] e1, input logic eb, input logic [15:0] ec);
        vec_t t;
        t = '{rst: r, freeze: fz, flush: fl, valid: va, rs0: s0, rs1: s1, used: us, rd: d,
              wr: w, ld: l, e_stall: es, e_sel0: e0, e_sel1: e1, e_bub: eb, e_cnt: ec};
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(negedge clk);
        rst        = t.rst;
        freeze     = t.freeze;
        flush      = t.flush;
        id_valid   = t.valid;
        id_rs      = {t.rs1, t.rs0};
        id_rs_used = t.used;
        id_rd      = t.rd;
        id_wr_en   = t.wr;
        id_is_load = t.ld;
        #1;
        chk("stall_id", idx, {31'd0, stall_id}, {31'd0, t.e_stall});
        @(posedge clk);
        #1;
        chk("fwd_sel0", idx, {30'd0, fwd_sel[1:0]}, {30'd0, t.e_sel0});
        chk("fwd_sel1", idx, {30'd0, fwd_sel[3:2]}, {30'd0, t.e_sel1});
        chk("bubble_ex", idx, {31'd0, bubble_ex}, {31'd0, t.e_bub});
        chk("stall_cnt", idx, {16'd0, stall_cnt}, {16'd0, t.e_cnt});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; id_valid = 1'b0; id_rs = '0;
        id_rs_used = '0; id_rd = '0; id_wr_en = 1'b0; id_is_load = 1'b0;

        // rst fr fl va rs0 rs1 used rd wr ld | stall sel0 sel1 bub cnt
        vecs.push_back(mk(1, 0, 0, 0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1,  5,  0, 2'b01,  1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  1,  2, 2'b11,  5, 1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  5,  7, 2'b11,  6, 1, 0, 0, 1, 0, 0, 0));
        // Youngest producer wins, then ages out
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00,  8, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00,  8, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  8,  6, 2'b11,  0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  8,  0, 2'b01,  0, 0, 0, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  8,  0, 2'b01,  0, 0, 0, 0, 0, 0, 0, 0));
        // Load-use: one stall cycle then MEM/WB forward
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00,  5, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1,  5,  5, 2'b11,  6, 1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  5,  5, 2'b11,  6, 1, 0, 0, 2, 2, 0, 1));
        // Freeze during a load-use stall
        vecs.push_back(mk(1, 0, 0, 0,  0,  0, 2'b00,  0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00,  9, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            vecs.push_back(mk(0, 1, 0, 1, 9, 9, 2'b11, 10, 1, 0, 1, 0, 0, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 1,  9,  9, 2'b11, 10, 1, 0, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1,  9,  9, 2'b11, 10, 1, 0, 0, 2, 2, 0, 1));
        // Flush beats stall; flushed rd12 never enters the shadow
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00, 11, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 11, 10, 2'b11, 12, 1, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 12, 11, 2'b11,  0, 0, 0, 0, 0, 2, 0, 1));
        // x0 load never forwards nor stalls
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00,  0, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b11,  0, 0, 0, 0, 0, 0, 0, 1));
        // Unused operands and invalid ID never stall or select
        vecs.push_back(mk(0, 0, 0, 1,  0,  0, 2'b00, 13, 1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 13, 13, 2'b00,  0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 13, 13, 2'b11,  0, 0, 0, 0, 0, 0, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Hand sequence: a load-use hazard presented while rst is high must not stall
        apply(mk(0, 0, 0, 1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0, 0, 1), 100);
        apply(mk(1, 0, 0, 1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 1, 0), 101);
        apply(mk(0, 0, 0, 1, 3, 3, 2'b11, 4, 1, 0, 0, 0, 0, 0, 0), 102);
        apply(mk(0, 0, 0, 1, 4, 0, 2'b01, 0, 0, 0, 0, 1, 0, 0, 0), 103);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
